// File: rtl/rv32ima_soc_pkg.sv
// Shared definitions for the rv32ima SoC slice: reset levels, address map,
// opcode encodings and the byte-lane merge helper used by RAM and tohost.
package rv32ima_soc_pkg;

   localparam logic        RstEnable  = 1'b0;
   localparam logic        RstDisable = 1'b1;
   localparam logic [31:0] ZeroWord   = 32'h0000_0000;

   localparam logic [31:0] RomBase    = 32'h0000_0000;
   localparam logic [31:0] RamBase    = 32'h0001_0000;
   localparam logic [31:0] ToHostAddr = 32'h0002_0000;

   typedef enum logic [6:0] {
      OP_LUI    = 7'b0110111,
      OP_AUIPC  = 7'b0010111,
      OP_JAL    = 7'b1101111,
      OP_JALR   = 7'b1100111,
      OP_BRANCH = 7'b1100011,
      OP_LOAD   = 7'b0000011,
      OP_STORE  = 7'b0100011,
      OP_IMM    = 7'b0010011,
      OP_REG    = 7'b0110011,
      OP_AMO    = 7'b0101111
   } opcode_e;

   // Replace only the byte lanes whose select bit is set.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  sel);
      logic [31:0] r;
      r = old_word;
      for (int unsigned i = 0; i < 4; i++)
         if (sel[i]) r[8*i +: 8] = new_word[8*i +: 8];
      return r;
   endfunction

endpackage

// File: rtl/inst_rom.sv
// Instruction ROM with two combinational read ports: the fetch port and a
// data-bus port. Contents are loaded externally into inst_mem; reads outside
// the ROM window or with the enable low return zero.
// Ports: ce/addr/inst (fetch), rd_en/rd_addr/rd_data (data bus).
module inst_rom
   import rv32ima_soc_pkg::*;
#(
   parameter int unsigned ROM_WORDS = 1024
)(
   input  logic        ce,
   input  logic [31:0] addr,
   output logic [31:0] inst,
   input  logic        rd_en,
   input  logic [31:0] rd_addr,
   output logic [31:0] rd_data
);

   localparam int unsigned Aw       = $clog2(ROM_WORDS);
   localparam int unsigned RomBytes = ROM_WORDS * 4;

   logic [31:0] inst_mem [0:ROM_WORDS-1];
   logic [31:0] inst_off, rd_off;

   assign inst_off = addr - RomBase;
   assign rd_off   = rd_addr - RomBase;

   assign inst    = (ce && inst_off < RomBytes) ? inst_mem[inst_off[Aw+1:2]] : ZeroWord;
   assign rd_data = (rd_en && rd_off < RomBytes) ? inst_mem[rd_off[Aw+1:2]] : ZeroWord;

endmodule

// File: rtl/rv32ima_core.sv
// Single-cycle RV32IMA core. Fetch and data reads are combinational; register
// file, PC and memory writes update on the rising clock edge.
// Ports: clk_i, rst_i (async, active-low); instruction port inst_addr_o,
// inst_ce_o, inst_i; data port data_addr_o, data_wdata_o, data_we_o,
// data_sel_o, data_ce_o, data_rdata_i.
module rv32ima_core
   import rv32ima_soc_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   output logic [31:0] inst_addr_o,
   output logic        inst_ce_o,
   input  logic [31:0] inst_i,
   output logic [31:0] data_addr_o,
   output logic [31:0] data_wdata_o,
   output logic        data_we_o,
   output logic [3:0]  data_sel_o,
   output logic        data_ce_o,
   input  logic [31:0] data_rdata_i
);

   logic [31:0] pc, pc_next;
   logic        run;
   logic [31:0] regs [0:31];
   logic        rsv_valid, rsv_set, rsv_clr;
   logic [31:0] rsv_addr;

   opcode_e     opc;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [31:0] rs1_v, rs2_v, rd_v, ea, ld_v, ld_sh, mdu_v, amo_v;
   logic [63:0] prod;
   logic        rd_we, take, ovf;

   assign opc   = opcode_e'(inst_i[6:0]);
   assign rd    = inst_i[11:7];
   assign f3    = inst_i[14:12];
   assign rs1   = inst_i[19:15];
   assign rs2   = inst_i[24:20];
   assign f7    = inst_i[31:25];
   assign imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
   assign imm_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
   assign imm_b = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
   assign imm_u = {inst_i[31:12], 12'h000};
   assign imm_j = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

   assign rs1_v = (rs1 == 5'd0) ? ZeroWord : regs[rs1];
   assign rs2_v = (rs2 == 5'd0) ? ZeroWord : regs[rs2];
   assign ea    = rs1_v + ((opc == OP_STORE) ? imm_s : imm_i);

   assign inst_addr_o = pc;
   assign inst_ce_o   = run;

   function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                       input logic [2:0] op, input logic alt);
      case (op)
         3'b000:  alu = alt ? a - b : a + b;
         3'b001:  alu = a << b[4:0];
         3'b010:  alu = {31'd0, $signed(a) < $signed(b)};
         3'b011:  alu = {31'd0, a < b};
         3'b100:  alu = a ^ b;
         3'b101:  alu = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
         3'b110:  alu = a | b;
         default: alu = a & b;
      endcase
   endfunction

   // One 64-bit multiplier serves all four MUL variants; operand extension
   // picks signedness, MUL itself only uses the low half.
   assign prod = {{32{(f3 == 3'b001 || f3 == 3'b010) && rs1_v[31]}}, rs1_v} *
                 {{32{(f3 == 3'b001) && rs2_v[31]}}, rs2_v};
   assign ovf  = (rs1_v == 32'h8000_0000) && (rs2_v == '1);

   always_comb begin
      case (f3)
         3'b000:  mdu_v = prod[31:0];
         3'b001,
         3'b010,
         3'b011:  mdu_v = prod[63:32];
         3'b100:  mdu_v = (rs2_v == '0) ? '1 : ovf ? rs1_v : 32'($signed(rs1_v) / $signed(rs2_v));
         3'b101:  mdu_v = (rs2_v == '0) ? '1 : rs1_v / rs2_v;
         3'b110:  mdu_v = (rs2_v == '0) ? rs1_v : ovf ? '0 : 32'($signed(rs1_v) % $signed(rs2_v));
         default: mdu_v = (rs2_v == '0) ? rs1_v : rs1_v % rs2_v;
      endcase
   end

   always_comb begin
      case (f7[6:2])
         5'b00000: amo_v = data_rdata_i + rs2_v;
         5'b00100: amo_v = data_rdata_i ^ rs2_v;
         5'b01100: amo_v = data_rdata_i & rs2_v;
         5'b01000: amo_v = data_rdata_i | rs2_v;
         5'b10000: amo_v = ($signed(data_rdata_i) < $signed(rs2_v)) ? data_rdata_i : rs2_v;
         5'b10100: amo_v = ($signed(data_rdata_i) > $signed(rs2_v)) ? data_rdata_i : rs2_v;
         5'b11000: amo_v = (data_rdata_i < rs2_v) ? data_rdata_i : rs2_v;
         5'b11100: amo_v = (data_rdata_i > rs2_v) ? data_rdata_i : rs2_v;
         default:  amo_v = rs2_v;
      endcase
   end

   assign ld_sh = data_rdata_i >> {ea[1:0], 3'b000};
   always_comb begin
      case (f3)
         3'b000:  ld_v = {{24{ld_sh[7]}}, ld_sh[7:0]};
         3'b001:  ld_v = {{16{ld_sh[15]}}, ld_sh[15:0]};
         3'b100:  ld_v = {24'd0, ld_sh[7:0]};
         3'b101:  ld_v = {16'd0, ld_sh[15:0]};
         default: ld_v = data_rdata_i;
      endcase
   end

   always_comb begin
      case (f3)
         3'b000:  take = rs1_v == rs2_v;
         3'b001:  take = rs1_v != rs2_v;
         3'b100:  take = $signed(rs1_v) < $signed(rs2_v);
         3'b101:  take = $signed(rs1_v) >= $signed(rs2_v);
         3'b110:  take = rs1_v < rs2_v;
         3'b111:  take = rs1_v >= rs2_v;
         default: take = 1'b0;
      endcase
   end

   always_comb begin
      pc_next      = pc + 32'd4;
      rd_v         = ZeroWord;
      rd_we        = 1'b0;
      data_addr_o  = ZeroWord;
      data_wdata_o = ZeroWord;
      data_we_o    = 1'b0;
      data_sel_o   = '0;
      data_ce_o    = 1'b0;
      rsv_set      = 1'b0;
      rsv_clr      = 1'b0;
      if (run) begin
         case (opc)
            OP_LUI:   begin rd_v = imm_u;      rd_we = 1'b1; end
            OP_AUIPC: begin rd_v = pc + imm_u; rd_we = 1'b1; end
            OP_JAL: begin
               rd_v = pc + 32'd4; rd_we = 1'b1; pc_next = pc + imm_j;
            end
            OP_JALR: begin
               rd_v = pc + 32'd4; rd_we = 1'b1; pc_next = (rs1_v + imm_i) & ~32'd1;
            end
            OP_BRANCH: if (take) pc_next = pc + imm_b;
            OP_LOAD: begin
               data_addr_o = ea; data_ce_o = 1'b1; rd_v = ld_v; rd_we = 1'b1;
            end
            OP_STORE: begin
               data_addr_o = ea; data_ce_o = 1'b1; data_we_o = 1'b1;
               case (f3[1:0])
                  2'b00: begin
                     data_sel_o = 4'b0001 << ea[1:0]; data_wdata_o = {4{rs2_v[7:0]}};
                  end
                  2'b01: begin
                     data_sel_o = 4'b0011 << {ea[1], 1'b0}; data_wdata_o = {2{rs2_v[15:0]}};
                  end
                  default: begin
                     data_sel_o = 4'b1111; data_wdata_o = rs2_v;
                  end
               endcase
            end
            OP_IMM: begin
               rd_v  = alu(rs1_v, imm_i, f3, (f3 == 3'b101) && inst_i[30]);
               rd_we = 1'b1;
            end
            OP_REG: begin
               rd_v  = (f7 == 7'b0000001) ? mdu_v : alu(rs1_v, rs2_v, f3, inst_i[30]);
               rd_we = 1'b1;
            end
            OP_AMO: begin
               // Read-modify-write completes in one cycle: the old word comes
               // back combinationally and the new word lands on the clock edge.
               data_addr_o = rs1_v; data_ce_o = 1'b1; rd_v = data_rdata_i; rd_we = 1'b1;
               case (f7[6:2])
                  5'b00010: rsv_set = 1'b1;
                  5'b00011: begin
                     rsv_clr = 1'b1;
                     if (rsv_valid && rsv_addr == rs1_v) begin
                        data_we_o = 1'b1; data_sel_o = 4'b1111; data_wdata_o = rs2_v; rd_v = ZeroWord;
                     end else begin
                        rd_v = 32'd1;
                     end
                  end
                  default: begin
                     data_we_o = 1'b1; data_sel_o = 4'b1111; data_wdata_o = amo_v;
                  end
               endcase
            end
            default: ;
         endcase
      end
   end

   // run gates execution for the first cycle after reset so fetch starts
   // cleanly at address 0.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (rst_i == RstEnable) begin
         pc        <= ZeroWord;
         run       <= 1'b0;
         rsv_valid <= 1'b0;
         rsv_addr  <= ZeroWord;
      end else begin
         run <= RstDisable;
         if (run) pc <= pc_next;
         if (rsv_set) begin
            rsv_valid <= 1'b1;
            rsv_addr  <= rs1_v;
         end else if (rsv_clr) begin
            rsv_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rd_we && rd != 5'd0) regs[rd] <= rd_v;
   end

endmodule

// File: rtl/rv32ima_soc_top.sv
// SoC slice: rv32ima core, instruction ROM, byte-writable data RAM and the
// tohost register, decoded on a flat 32-bit data bus.
// Ports: clk_i (rising edge), rst_i (async, active-low).
module rv32ima_soc_top
   import rv32ima_soc_pkg::*;
#(
   parameter int unsigned ROM_WORDS = 1024,
   parameter int unsigned RAM_WORDS = 1024
)(
   input  logic clk_i,
   input  logic rst_i
);

   localparam int unsigned RamAw    = $clog2(RAM_WORDS);
   localparam int unsigned RamBytes = RAM_WORDS * 4;

   logic [31:0]      inst_addr, inst_data;
   logic             inst_ce;
   logic [31:0]      data_addr, data_wdata, data_rdata, rom_data;
   logic             data_we, data_ce;
   logic [3:0]       data_sel;
   logic [31:0]      ram_off, tohost;
   logic [RamAw-1:0] ram_idx;
   logic             in_ram, is_tohost;
   logic [31:0]      ram [0:RAM_WORDS-1];

   rv32ima_core core_0 (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .inst_addr_o  (inst_addr),
      .inst_ce_o    (inst_ce),
      .inst_i       (inst_data),
      .data_addr_o  (data_addr),
      .data_wdata_o (data_wdata),
      .data_we_o    (data_we),
      .data_sel_o   (data_sel),
      .data_ce_o    (data_ce),
      .data_rdata_i (data_rdata)
   );

   inst_rom #(.ROM_WORDS(ROM_WORDS)) rom_0 (
      .ce      (inst_ce),
      .addr    (inst_addr),
      .inst    (inst_data),
      .rd_en   (data_ce),
      .rd_addr (data_addr),
      .rd_data (rom_data)
   );

   assign ram_off   = data_addr - RamBase;
   assign in_ram    = ram_off < RamBytes;
   assign ram_idx   = ram_off[RamAw+1:2];
   assign is_tohost = data_addr[31:2] == ToHostAddr[31:2];

   // ROM returns zero outside its own window, so it is the fall-through case.
   always_comb begin
      data_rdata = ZeroWord;
      if (data_ce) begin
         if (in_ram)         data_rdata = ram[ram_idx];
         else if (is_tohost) data_rdata = tohost;
         else                data_rdata = rom_data;
      end
   end

   always_ff @(posedge clk_i) begin
      if (data_ce && data_we && in_ram)
         ram[ram_idx] <= merge_bytes(ram[ram_idx], data_wdata, data_sel);
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (rst_i == RstEnable)
         tohost <= ZeroWord;
      else if (data_ce && data_we && is_tohost)
         tohost <= merge_bytes(tohost, data_wdata, data_sel);
   end

endmodule

// File: tb/tb_rv32ima_soc_top.sv
// Directed bench for rv32ima_soc_top: programs are hand-encoded into the ROM
// and results observed through tohost, RAM and the fetch bus.
module tb_rv32ima_soc_top;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fails  = 0;
   logic [31:0] prog [0:15];

   always #10 clk = ~clk;

   rv32ima_soc_top #(.ROM_WORDS(64), .RAM_WORDS(64)) dut (
      .clk_i (clk),
      .rst_i (rst_n)
   );

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {imm, rd, op};
   endfunction

   function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
   endfunction

   function automatic logic [31:0] enc_j(input logic [20:0] off, input logic [4:0] rd);
      return {off[20], off[10:1], off[11], off[19:12], rd, 7'h6F};
   endfunction

   task automatic load_rom(input int n);
      for (int i = 0; i < 64; i++) dut.rom_0.inst_mem[i] = 32'h0;
      for (int i = 0; i < n; i++) dut.rom_0.inst_mem[i] = prog[i];
   endtask

   task automatic test_reset();
      logic we_seen;
      we_seen = 1'b0;
      prog[0] = enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13);
      prog[1] = enc_u(20'h00020, 5'd2, 7'h37);
      prog[2] = enc_s(12'd0, 5'd1, 5'd2, 3'd2);
      prog[3] = enc_j(21'd0, 5'd0);
      load_rom(4);
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         if (dut.data_ce && dut.data_we) we_seen = 1'b1;
      end
      #10;
      n_checks++;
      if (dut.tohost !== 32'h0) begin
         n_fails++; $display("FAIL reset_tohost: got %h want %h", dut.tohost, 32'h0);
      end
      n_checks++;
      if (dut.inst_ce !== 1'b0) begin
         n_fails++; $display("FAIL reset_inst_ce: got %b want 0", dut.inst_ce);
      end
      n_checks++;
      if (we_seen !== 1'b0) begin
         n_fails++; $display("FAIL reset_no_write: got %b want 0", we_seen);
      end
   endtask

   task automatic test_program_store();
      #5 rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (dut.inst_ce !== 1'b1 || dut.inst_addr !== 32'h0) begin
         n_fails++;
         $display("FAIL first_fetch: got ce=%b addr=%h want ce=1 addr=%h", dut.inst_ce, dut.inst_addr, 32'h0);
      end
      for (int i = 0; i < 20 && dut.tohost !== 32'h5; i++) @(negedge clk);
      n_checks++;
      if (dut.tohost !== 32'h0000_0005) begin
         n_fails++; $display("FAIL store_tohost: got %h want %h", dut.tohost, 32'h0000_0005);
      end
   endtask

   task automatic wait_oob_fetch(input string name);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (dut.inst_ce && dut.inst_addr == 32'd256) begin
            found = 1'b1;
            break;
         end
      end
      n_checks++;
      if (found !== 1'b1) begin
         n_fails++; $display("FAIL %s: got timeout want fetch at %h", name, 32'd256);
      end
   endtask

   task automatic test_byte_lane();
      rst_n = 1'b0;
      #1;
      prog[0]  = enc_u(20'h11223, 5'd3, 7'h37);
      prog[1]  = enc_i(12'h344, 5'd3, 3'd0, 5'd3, 7'h13);
      prog[2]  = enc_u(20'h00010, 5'd4, 7'h37);
      prog[3]  = enc_s(12'd0, 5'd3, 5'd4, 3'd2);
      prog[4]  = enc_s(12'd4, 5'd3, 5'd4, 3'd2);
      prog[5]  = enc_i(12'h0AB, 5'd0, 3'd0, 5'd5, 7'h13);
      prog[6]  = enc_s(12'd1, 5'd5, 5'd4, 3'd0);
      prog[7]  = enc_i(12'd0, 5'd4, 3'd2, 5'd6, 7'h03);
      prog[8]  = enc_u(20'h00020, 5'd2, 7'h37);
      prog[9]  = enc_s(12'd0, 5'd6, 5'd2, 3'd2);
      prog[10] = enc_s(12'd16, 5'd6, 5'd0, 3'd2);
      prog[11] = enc_u(20'h00030, 5'd7, 7'h37);
      prog[12] = enc_i(12'd0, 5'd7, 3'd2, 5'd8, 7'h03);
      prog[13] = enc_s(12'd4, 5'd8, 5'd4, 3'd2);
      prog[14] = enc_j(21'd200, 5'd0);
      load_rom(15);
      @(negedge clk);
      #5 rst_n = 1'b1;
      wait_oob_fetch("oob_fetch_reached");
      n_checks++;
      if (dut.inst_data !== 32'h0) begin
         n_fails++; $display("FAIL oob_fetch_zero: got %h want %h", dut.inst_data, 32'h0);
      end
      n_checks++;
      if (dut.tohost !== 32'h1122_AB44) begin
         n_fails++; $display("FAIL byte_lane_tohost: got %h want %h", dut.tohost, 32'h1122_AB44);
      end
      n_checks++;
      if (dut.ram[0] !== 32'h1122_AB44) begin
         n_fails++; $display("FAIL byte_lane_ram: got %h want %h", dut.ram[0], 32'h1122_AB44);
      end
      n_checks++;
      if (dut.ram[1] !== 32'h0) begin
         n_fails++; $display("FAIL unmapped_read: got %h want %h", dut.ram[1], 32'h0);
      end
      n_checks++;
      if (dut.rom_0.inst_mem[4] !== prog[4]) begin
         n_fails++; $display("FAIL rom_write_ignored: got %h want %h", dut.rom_0.inst_mem[4], prog[4]);
      end
   endtask

   task automatic test_mid_run_reset();
      repeat (30) @(negedge clk);
      #5 rst_n = 1'b0;
      #1;
      n_checks++;
      if (dut.tohost !== 32'h0) begin
         n_fails++; $display("FAIL midrst_tohost: got %h want %h", dut.tohost, 32'h0);
      end
      n_checks++;
      if (dut.inst_ce !== 1'b0) begin
         n_fails++; $display("FAIL midrst_inst_ce: got %b want 0", dut.inst_ce);
      end
      n_checks++;
      if (dut.inst_addr !== 32'h0) begin
         n_fails++; $display("FAIL midrst_pc: got %h want %h", dut.inst_addr, 32'h0);
      end
      n_checks++;
      if (dut.ram[0] !== 32'h1122_AB44) begin
         n_fails++; $display("FAIL midrst_ram0: got %h want %h", dut.ram[0], 32'h1122_AB44);
      end
      n_checks++;
      if (dut.ram[1] !== 32'h0) begin
         n_fails++; $display("FAIL midrst_ram1: got %h want %h", dut.ram[1], 32'h0);
      end
      repeat (2) @(negedge clk);
      #5 rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (dut.inst_ce !== 1'b1) begin
         n_fails++; $display("FAIL restart_ce: got %b want 1", dut.inst_ce);
      end
      n_checks++;
      if (dut.inst_addr !== 32'h0) begin
         n_fails++; $display("FAIL restart_pc: got %h want %h", dut.inst_addr, 32'h0);
      end
      wait_oob_fetch("rerun_reached");
      n_checks++;
      if (dut.tohost !== 32'h1122_AB44) begin
         n_fails++; $display("FAIL rerun_tohost: got %h want %h", dut.tohost, 32'h1122_AB44);
      end
   endtask

   initial begin
      test_reset();
      test_program_store();
      test_byte_lane();
      test_mid_run_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
